interval_counter: RTL and testbench

- Consumes the start/stop test pulses from the TDC test pulse source.
- Measures the coarse interval between a start rising edge and the next stop rising edge, in clk cycles.
- Queues each result in a small FIFO and presents it on a valid/ready interface for readout logic (AXI register bank / DMA packer).
- Serves as the coarse-count reference against which fine-TDC results are checked.

---
 rtl/interval_counter.sv | 131 +++++++++++++
 tb/tb_interval_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/interval_counter.sv
// Coarse interval counter: measures clk cycles from a start rise to the next stop rise
// and queues {timeout_flag, count} results in a small first-word-fall-through FIFO.
module interval_counter #(
    parameter int unsigned    CW        = 16,
    parameter logic [CW-1:0]  MAX_COUNT = 16'hFFFF,
    parameter int unsigned    DEPTH     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          start_in,
    input  logic          stop_in,
    output logic [CW:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          push;
    logic [CW:0]   push_data;

    logic start_q, start_q_d, stop_q, stop_q_d;
    logic start_rise, stop_rise;

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [CW:0]   mem [DEPTH];
    logic          empty, full, pop, do_push, drop;

    // Pulses arrive on negedge clk; one register stage, then one more for edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q   <= 1'b0;
            start_q_d <= 1'b0;
            stop_q    <= 1'b0;
            stop_q_d  <= 1'b0;
        end else begin
            start_q   <= start_in;
            start_q_d <= start_q;
            stop_q    <= stop_in;
            stop_q_d  <= stop_q;
        end
    end

    assign start_rise = start_q & ~start_q_d;
    assign stop_rise  = stop_q & ~stop_q_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        push      = 1'b0;
        push_data = '0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rise && stop_rise) begin
                        push = 1'b1;
                    end else if (start_rise) begin
                        state_nxt = COUNT;
                        cnt_nxt   = CW'(1);
                    end
                end
                COUNT: begin
                    // A start rise while counting is deliberately ignored (no restart).
                    if (stop_rise) begin
                        push      = 1'b1;
                        push_data = {1'b0, cnt};
                        state_nxt = IDLE;
                    end else if (cnt == MAX_COUNT) begin
                        push      = 1'b1;
                        push_data = {1'b1, MAX_COUNT};
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state == COUNT);

    // Handshake: out_valid means the head entry on out_data is stable; it is consumed on
    // any posedge where out_valid & out_ready, and out_valid never drops without a pop.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign do_push   = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign out_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            // A drop in the same cycle as a clear wins, so no loss goes unreported.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_interval_counter.sv
// Bench for interval_counter: directed scenarios plus random pulses, checked every cycle
// against a start-time/queue model of the measurement and result FIFO.
module tb_interval_counter;

    localparam int CW    = 16;
    localparam int MAXC  = 20;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          start_in = 1'b0;
    logic          stop_in = 1'b0;
    logic [CW:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          overflow;
    logic          ovf_clr = 1'b0;
    logic          busy;

    interval_counter #(.CW(CW), .MAX_COUNT(16'd20), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .en(en), .start_in(start_in), .stop_in(stop_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a measurement is "open" since edge m_tstart; result = elapsed edges.
    logic [CW:0] m_q[$];
    bit          m_open, m_ovf;
    int          m_tstart, edge_no;
    bit          pend_st, pend_sp, s_prev, p_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_open  = 0;
        m_ovf   = 0;
        pend_st = 0;
        pend_sp = 0;
        s_prev  = 0;
        p_prev  = 0;
    endtask

    task automatic model_edge();
        bit          res_v;
        logic [CW:0] res;
        bit          pop;
        int          n;
        edge_no++;
        res_v = 0;
        res   = '0;
        pop   = out_ready && (m_q.size() > 0);
        if (!en) begin
            m_open = 0;
        end else if (m_open) begin
            n = edge_no - m_tstart;
            if (pend_sp) begin
                res_v = 1; res = (CW+1)'(n); m_open = 0;
            end else if (n == MAXC) begin
                res_v = 1; res = {1'b1, CW'(MAXC)}; m_open = 0;
            end
        end else if (pend_st) begin
            if (pend_sp) begin
                res_v = 1; res = '0;
            end else begin
                m_open = 1; m_tstart = edge_no;
            end
        end
        pend_st = start_in && !s_prev;
        pend_sp = stop_in && !p_prev;
        s_prev  = start_in;
        p_prev  = stop_in;
        if (pop) void'(m_q.pop_front());
        if (res_v && m_q.size() == DEPTH) m_ovf = 1;
        else begin
            if (res_v) m_q.push_back(res);
            if (ovf_clr) m_ovf = 0;
        end
    endtask

    task automatic check_outputs();
        check("valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("data", out_data, m_q[0]);
        check("busy", busy, m_open);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pair(input int n);
        if (n == 0) begin
            start_in = 1; stop_in = 1; cycle();
            start_in = 0; stop_in = 0; cycle();
        end else begin
            start_in = 1; cycle();
            start_in = 0; idle(n - 1);
            stop_in = 1; cycle();
            stop_in = 0; cycle();
        end
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        model_clear();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    initial begin
        edge_no = 0;
        do_reset();
        en = 1; out_ready = 1;

        // Periodic N=10 measurements.
        for (int k = 0; k < 3; k++) begin
            pair(10);
            idle(20);
        end

        // Start and stop in the same cycle.
        pair(0);
        idle(5);

        // Start without stop: timeout, then a late stop produces nothing.
        start_in = 1; cycle();
        start_in = 0; idle(30);
        stop_in = 1; cycle();
        stop_in = 0; idle(5);

        // Stalled consumer: fifth result is dropped.
        out_ready = 0;
        for (int n = 3; n <= 7; n++) begin
            pair(n);
            idle(3);
        end
        check("ovf_set", overflow, 1);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("drain", out_data, 3 + i);
            cycle();
        end
        check("drained", out_valid, 0);
        ovf_clr = 1; cycle();
        ovf_clr = 0;
        check("ovf_clr", overflow, 0);

        // Enable dropped mid-measurement.
        start_in = 1; cycle();
        start_in = 0; idle(5);
        en = 0; idle(3);
        en = 1; idle(35);
        stop_in = 1; cycle();
        stop_in = 0; idle(3);
        pair(8);
        idle(3);

        // Reset mid-measurement with two entries queued.
        out_ready = 0;
        pair(4);
        pair(5);
        start_in = 1; cycle();
        start_in = 0; idle(3);
        do_reset();
        out_ready = 1;
        pair(12);
        idle(3);

        // Random pulses, enable, back-pressure and clears.
        for (int i = 0; i < 800; i++) begin
            en        = ($urandom_range(0, 15) != 0);
            start_in  = ($urandom_range(0, 7) == 0);
            stop_in   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 31) == 0);
            cycle();
        end
        en = 1; start_in = 0; stop_in = 0; out_ready = 1; ovf_clr = 0;
        idle(30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
